// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences one memory op per cycle over
// six March elements and checks registered read data one cycle after each read.
module mbist_march_ctrl #(
  parameter int ROW_ADDR_BITS = 4,
  parameter int COL_ADDR_BITS = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     mem_wr_en,
  output logic [ROW_ADDR_BITS-1:0] mem_row,
  output logic [COL_ADDR_BITS-1:0] mem_col,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [ROW_ADDR_BITS-1:0] fail_row,
  output logic [COL_ADDR_BITS-1:0] fail_col,
  output logic [2:0]               fail_elem
);

  localparam int AW = ROW_ADDR_BITS + COL_ADDR_BITS;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;

  // elem/addr describe the op currently on the memory port; mem_wr_en is its phase
  logic [2:0]    elem;
  logic [AW-1:0] addr;

  logic [2:0]            next_elem;
  logic [AW-1:0]         next_addr;
  logic                  next_wr;
  logic [DATA_WIDTH-1:0] next_data;
  logic                  last_op;
  logic                  down;
  logic                  at_end;
  logic [DATA_WIDTH-1:0] read_exp;

  logic                     pend_valid;
  logic [DATA_WIDTH-1:0]    pend_exp;
  logic [ROW_ADDR_BITS-1:0] pend_row;
  logic [COL_ADDR_BITS-1:0] pend_col;
  logic [2:0]               pend_elem;

  always_comb begin
    next_elem = elem;
    next_addr = addr;
    next_wr   = 1'b0;
    next_data = '0;
    last_op   = 1'b0;
    down      = (elem == 3'd3) || (elem == 3'd4);
    at_end    = down ? (addr == '0) : (addr == ADDR_LAST);
    read_exp  = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
    case (elem)
      3'd0: begin
        if (at_end) begin
          next_elem = 3'd1;
          next_addr = '0;
        end else begin
          next_addr = addr + ADDR_ONE;
          next_wr   = 1'b1;
        end
      end
      3'd5: begin
        if (at_end) last_op = 1'b1;
        else        next_addr = addr + ADDR_ONE;
      end
      default: begin
        // A read is always followed by the write at the same address
        if (!mem_wr_en) begin
          next_wr = 1'b1;
        end else if (at_end) begin
          next_elem = elem + 3'd1;
          next_addr = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : '0;
        end else begin
          next_addr = down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
        end
      end
    endcase
    if (next_wr && ((next_elem == 3'd1) || (next_elem == 3'd3))) next_data = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      elem        <= '0;
      addr        <= '0;
      mem_wr_en   <= 1'b0;
      mem_row     <= '0;
      mem_col     <= '0;
      mem_data_in <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_row    <= '0;
      fail_col    <= '0;
      fail_elem   <= '0;
      pend_valid  <= 1'b0;
      pend_exp    <= '0;
      pend_row    <= '0;
      pend_col    <= '0;
      pend_elem   <= '0;
    end else begin
      // Compare stage: mem_data_out now holds the data for the read registered last cycle
      if (pend_valid && (mem_data_out != pend_exp)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_row  <= pend_row;
          fail_col  <= pend_col;
          fail_elem <= pend_elem;
        end
      end
      pend_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_row    <= '0;
            fail_col    <= '0;
            fail_elem   <= '0;
            elem        <= '0;
            addr        <= '0;
            mem_wr_en   <= 1'b1;
            mem_row     <= '0;
            mem_col     <= '0;
            mem_data_in <= '0;
          end
        end
        RUN: begin
          pend_valid <= !mem_wr_en;
          pend_exp   <= read_exp;
          pend_row   <= mem_row;
          pend_col   <= mem_col;
          pend_elem  <= elem;
          if (last_op) begin
            state       <= DRAIN;
            mem_wr_en   <= 1'b0;
            mem_row     <= '0;
            mem_col     <= '0;
            mem_data_in <= '0;
          end else begin
            elem                <= next_elem;
            addr                <= next_addr;
            mem_wr_en           <= next_wr;
            {mem_row, mem_col}  <= next_addr;
            mem_data_in         <= next_data;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 Parameter ROW_ADDR_BITS, default 4: memory row address width.
REQ-002 Parameter COL_ADDR_BITS, default 4: memory column address width.
REQ-003 Parameter DATA_WIDTH, default 8: memory word width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  level-sampled test request.
REQ-007 mem_wr_en  output  1  write enable to memory.
REQ-008 mem_row  output  ROW_ADDR_BITS  memory row address.
REQ-009 mem_col  output  COL_ADDR_BITS  memory column address.
REQ-010 mem_data_in  output  DATA_WIDTH  write data to memory.
REQ-011 mem_data_out  input  DATA_WIDTH  registered read data; reflects the address presented in the previous cycle, pre-write value.
REQ-012 busy  output  1  test in progress.
REQ-013 done  output  1  test complete; held until next accepted start.
REQ-014 fail  output  1  sticky: at least one miscompare this run.
REQ-015 fail_row / fail_col  output  ROW_ADDR_BITS / COL_ADDR_BITS  address of first miscompare.
REQ-016 fail_elem  output  3  March element index (0-5) of first miscompare.

Function
REQ-017 Algorithm SHALL be March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-018 Linear address A = {row,col}, N = 2^(ROW_ADDR_BITS+COL_ADDR_BITS); up = 0..N-1 (col fastest), down = N-1..0.
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE/DONE + start=1 -> RUN; clears done, fail, fail_row, fail_col, fail_elem; busy=1 from that edge.
REQ-021 start while RUN or DRAIN SHALL be ignored.
REQ-022 RUN: exactly one memory op per cycle, no idle cycles; read+write pairs at same address in consecutive cycles (read, then write); total RUN length 10N cycles.
REQ-023 Read op: mem_wr_en=0; write op: mem_wr_en=1, mem_data_in = background word.
REQ-024 Compare pipeline: each read registers expected value plus row/col/elem; mem_data_out compared full-width the following cycle.
REQ-025 After last M5 read, RUN -> DRAIN (1 cycle, final compare) -> DONE: done=1, busy=0.
REQ-026 Done latency: done visible 10N+1 edges after start-accepting edge.
REQ-027 Miscompare: fail=1; fail_row/fail_col/fail_elem latched only if fail was 0 (first failure kept); test continues to completion.
REQ-028 Outside RUN: mem_wr_en=0, mem_row=0, mem_col=0, mem_data_in=0.
REQ-029 Address counter wrap at element boundaries SHALL not emit duplicate or skipped addresses.

Reset
REQ-030 rst_n=0: state IDLE; mem_wr_en, mem_row, mem_col, mem_data_in, busy, done, fail, fail_row, fail_col, fail_elem all 0; compare pipeline invalidated.
REQ-031 Reset mid-run SHALL abort immediately without pending compare; next start begins at M0, A=0.

Verification (ROW=2, COL=2, WIDTH=8, N=16, fault-free memory unless stated)
REQ-032 Clean run: start pulse -> busy 160 RUN + 1 DRAIN cycles, done=1 at edge 161, fail=0; op log shows 16 w00, then r00/wFF x16 ascending, etc.
REQ-033 Stuck-at-1 bit0 at row1 col2 -> fail=1, fail_row=1, fail_col=2, fail_elem=1; done still at edge 161.
REQ-034 Stuck-at-0 bit7 at row3 col3 -> first miscompare M2 (r1) at A=15 -> fail_elem=2, fail_row=3, fail_col=3.
REQ-035 start held high during run -> no restart; after done, start=1 -> done, fail cleared, new run of 160+1 cycles.
REQ-036 rst_n low at cycle 50 of RUN -> all outputs 0 next sample, state IDLE; subsequent start gives clean 161-edge run.
